switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 149 ++++++++++++++
 tb/tb_switch_allocator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// 5x5 wormhole switch allocator: per-output round-robin head arbitration with
// packet locking, zero-cycle grant path and a sticky illegal-destination flag.
module switch_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_dest_i,
  input  logic [4:0]  req_tail_i,
  input  logic [4:0]  out_ready_i,
  output logic [4:0]  pop_req_o,
  output logic [4:0]  out_valid_o,
  output logic [14:0] out_sel_o,
  output logic [4:0]  busy_o,
  output logic        err_dest_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e     state_q [5];
  state_e     state_d [5];
  logic [2:0] owner_q [5];
  logic [2:0] owner_d [5];
  logic [2:0] ptr_q [5];
  logic [2:0] ptr_d [5];
  logic [4:0] in_lock_q, in_lock_d;
  logic [2:0] in_out_q [5];
  logic [2:0] in_out_d [5];
  logic       err_q, err_d;

  logic [2:0] dest_s [5];
  logic [4:0] gnt_s;
  logic [2:0] gnt_idx_s [5];

  function automatic logic [2:0] wrap5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  always_comb begin
    for (int k = 0; k < 5; k++) dest_s[k] = req_dest_i[3*k +: 3];
  end

  // Grant selection: locked outputs follow their owner, idle outputs search from ptr.
  always_comb begin
    logic [2:0] cand;
    logic [2:0] own;
    gnt_s       = 5'd0;
    pop_req_o   = 5'd0;
    out_valid_o = 5'd0;
    out_sel_o   = 15'd0;
    cand        = 3'd0;
    own         = 3'd0;
    for (int o = 0; o < 5; o++) gnt_idx_s[o] = 3'd0;
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        if (state_q[o] == LOCKED) begin
          own = owner_q[o];
          if (out_ready_i[o] && req_valid_i[own] && in_lock_q[own] && (in_out_q[own] == 3'(o))) begin
            gnt_s[o]     = 1'b1;
            gnt_idx_s[o] = own;
          end
        end else if (out_ready_i[o]) begin
          for (int i = 0; i < 5; i++) begin
            cand = wrap5(ptr_q[o], 3'(i));
            if (!gnt_s[o] && req_valid_i[cand] && !in_lock_q[cand] && (dest_s[cand] == 3'(o))) begin
              gnt_s[o]     = 1'b1;
              gnt_idx_s[o] = cand;
            end
          end
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (gnt_s[o]) begin
          pop_req_o[gnt_idx_s[o]] = 1'b1;
          out_valid_o[o]          = 1'b1;
          out_sel_o[3*o +: 3]     = gnt_idx_s[o];
        end
      end
    end
  end

  // Next state for locks, pointers and the sticky error flag.
  always_comb begin
    logic [2:0] k;
    k         = 3'd0;
    in_lock_d = in_lock_q;
    err_d     = err_q;
    for (int i = 0; i < 5; i++) begin
      state_d[i]  = state_q[i];
      owner_d[i]  = owner_q[i];
      ptr_d[i]    = ptr_q[i];
      in_out_d[i] = in_out_q[i];
      if (req_valid_i[i] && !in_lock_q[i] && (dest_s[i] > 3'd4)) err_d = 1'b1;
    end
    for (int o = 0; o < 5; o++) begin
      if (gnt_s[o]) begin
        k = gnt_idx_s[o];
        if (state_q[o] == IDLE) begin
          ptr_d[o] = (k == 3'd4) ? 3'd0 : k + 3'd1;
          if (!req_tail_i[k]) begin
            state_d[o]   = LOCKED;
            owner_d[o]   = k;
            in_lock_d[k] = 1'b1;
            in_out_d[k]  = 3'(o);
          end else begin
            state_d[o] = IDLE;
          end
        end else if (req_tail_i[k]) begin
          state_d[o]   = IDLE;
          in_lock_d[k] = 1'b0;
        end else begin
          state_d[o] = LOCKED;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_lock_q <= 5'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        state_q[i]  <= IDLE;
        owner_q[i]  <= 3'd0;
        ptr_q[i]    <= 3'd0;
        in_out_q[i] <= 3'd0;
      end
    end else begin
      in_lock_q <= in_lock_d;
      err_q     <= err_d;
      for (int i = 0; i < 5; i++) begin
        state_q[i]  <= state_d[i];
        owner_q[i]  <= owner_d[i];
        ptr_q[i]    <= ptr_d[i];
        in_out_q[i] <= in_out_d[i];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 5; o++) busy_o[o] = (state_q[o] == LOCKED);
  end

  assign err_dest_o = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid_i;
  logic [14:0] req_dest_i;
  logic [4:0]  req_tail_i;
  logic [4:0]  out_ready_i;
  logic [4:0]  pop_req_o;
  logic [4:0]  out_valid_o;
  logic [14:0] out_sel_o;
  logic [4:0]  busy_o;
  logic        err_dest_o;

  int total = 0;
  int bad   = 0;

  switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_dest_i(req_dest_i), .req_tail_i(req_tail_i),
    .out_ready_i(out_ready_i), .pop_req_o(pop_req_o), .out_valid_o(out_valid_o),
    .out_sel_o(out_sel_o), .busy_o(busy_o), .err_dest_o(err_dest_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] dp(input logic [2:0] n, input logic [2:0] s,
                                     input logic [2:0] e, input logic [2:0] w,
                                     input logic [2:0] l);
    return {l, w, e, s, n};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [14:0] d,
                       input logic [4:0] t, input logic [4:0] r);
    req_valid_i = v;
    req_dest_i  = d;
    req_tail_i  = t;
    out_ready_i = r;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'd0, 15'd0, 5'd0, 5'h1F);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] ep;
    rst = 1'b1;
    drive(5'h1F, dp(3'd0, 3'd0, 3'd0, 3'd0, 3'd0), 5'h1F, 5'h1F);
    chk("rst_pop", 32'(pop_req_o), 32'd0);
    chk("rst_oval", 32'(out_valid_o), 32'd0);
    chk("rst_sel", 32'(out_sel_o), 32'd0);
    cyc();
    cyc();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_dest_o), 32'd0);

    // single flit N -> E
    rst = 1'b0;
    drive(5'b00001, dp(3'd2, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00001, 5'h1F);
    chk("n2e_pop", 32'(pop_req_o), 32'b00001);
    chk("n2e_oval", 32'(out_valid_o), 32'b00100);
    chk("n2e_sel", 32'(out_sel_o), 32'd0);
    cyc();
    drive(5'b00011, dp(3'd2, 3'd2, 3'd0, 3'd0, 3'd0), 5'b00011, 5'h1F);
    chk("ptr2_pop", 32'(pop_req_o), 32'b00010);
    chk("ptr2_sel", 32'(out_sel_o), 32'd64);
    drive(5'b00011, dp(3'd2, 3'd2, 3'd0, 3'd0, 3'd0), 5'b00011, 5'b11011);
    chk("notready_pop", 32'(pop_req_o), 32'd0);
    drive(5'b00011, dp(3'd1, 3'd2, 3'd0, 3'd0, 3'd0), 5'b00011, 5'h1F);
    chk("two_out_pop", 32'(pop_req_o), 32'b00011);
    chk("two_out_oval", 32'(out_valid_o), 32'b00110);
    chk("two_out_sel", 32'(out_sel_o), 32'd64);
    cyc();

    // all five to L, round robin
    do_reset();
    drive(5'h1F, dp(3'd4, 3'd4, 3'd4, 3'd4, 3'd4), 5'h1F, 5'h1F);
    for (int i = 0; i < 6; i++) begin
      ep = 5'd1 << (i % 5);
      chk("rr_pop", 32'(pop_req_o), 32'(ep));
      chk("rr_sel", 32'(out_sel_o), 32'(i % 5) << 12);
      cyc();
    end

    // E 3-flit packet to N while W waits
    do_reset();
    drive(5'b01100, dp(3'd0, 3'd0, 3'd0, 3'd0, 3'd0), 5'b01000, 5'h1F);
    chk("wh1_pop", 32'(pop_req_o), 32'b00100);
    chk("wh1_sel", 32'(out_sel_o), 32'd2);
    cyc();
    chk("wh1_busy", 32'(busy_o), 32'b00001);
    drive(5'b01100, dp(3'd0, 3'd0, 3'd4, 3'd0, 3'd0), 5'b01000, 5'h1F);
    chk("wh2_pop", 32'(pop_req_o), 32'b00100);
    chk("wh2_oval", 32'(out_valid_o), 32'b00001);
    chk("wh2_sel", 32'(out_sel_o), 32'd2);
    cyc();
    chk("wh2_busy", 32'(busy_o), 32'b00001);
    drive(5'b01100, dp(3'd0, 3'd0, 3'd0, 3'd0, 3'd0), 5'b01100, 5'h1F);
    chk("wh3_pop", 32'(pop_req_o), 32'b00100);
    chk("wh3_sel", 32'(out_sel_o), 32'd2);
    cyc();
    chk("wh3_busy", 32'(busy_o), 32'd0);
    drive(5'b01000, dp(3'd0, 3'd0, 3'd0, 3'd0, 3'd0), 5'b01000, 5'h1F);
    chk("wh4_pop", 32'(pop_req_o), 32'b01000);
    chk("wh4_sel", 32'(out_sel_o), 32'd3);
    cyc();

    // locked packet stalled by out_ready
    do_reset();
    drive(5'b00010, dp(3'd0, 3'd3, 3'd0, 3'd0, 3'd0), 5'b00000, 5'h1F);
    chk("st_head_pop", 32'(pop_req_o), 32'b00010);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(5'b00010, dp(3'd0, 3'd3, 3'd0, 3'd0, 3'd0), 5'b00000, 5'b10111);
      chk("st_wait_pop", 32'(pop_req_o), 32'd0);
      chk("st_wait_oval", 32'(out_valid_o), 32'd0);
      cyc();
      chk("st_wait_busy", 32'(busy_o), 32'b01000);
    end
    drive(5'b00010, dp(3'd0, 3'd3, 3'd0, 3'd0, 3'd0), 5'b00010, 5'h1F);
    chk("st_res_pop", 32'(pop_req_o), 32'b00010);
    chk("st_res_sel", 32'(out_sel_o), 32'd512);
    cyc();
    chk("st_res_busy", 32'(busy_o), 32'd0);

    // illegal destination
    do_reset();
    drive(5'b00010, dp(3'd0, 3'd6, 3'd0, 3'd0, 3'd0), 5'b00010, 5'h1F);
    chk("bad_pop", 32'(pop_req_o), 32'd0);
    chk("bad_oval", 32'(out_valid_o), 32'd0);
    chk("bad_err_pre", 32'(err_dest_o), 32'd0);
    cyc();
    chk("bad_err_set", 32'(err_dest_o), 32'd1);
    drive(5'd0, 15'd0, 5'd0, 5'h1F);
    cyc();
    chk("bad_err_hold", 32'(err_dest_o), 32'd1);
    do_reset();
    chk("bad_err_clr", 32'(err_dest_o), 32'd0);

    // reset while output 1 locked
    drive(5'b00001, dp(3'd1, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00000, 5'h1F);
    chk("rl_head_pop", 32'(pop_req_o), 32'b00001);
    cyc();
    chk("rl_busy", 32'(busy_o), 32'b00010);
    rst = 1'b1;
    drive(5'b00101, dp(3'd1, 3'd0, 3'd1, 3'd0, 3'd0), 5'b00100, 5'h1F);
    chk("rl_rst_pop", 32'(pop_req_o), 32'd0);
    cyc();
    chk("rl_busy_clr", 32'(busy_o), 32'd0);
    rst = 1'b0;
    drive(5'b00100, dp(3'd1, 3'd0, 3'd1, 3'd0, 3'd0), 5'b00100, 5'h1F);
    chk("rl_new_pop", 32'(pop_req_o), 32'b00100);
    chk("rl_new_sel", 32'(out_sel_o), 32'd16);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
